// File: rtl/prog_fetch_unit_pkg.sv
// Shared constants, FSM encoding and sizing helper for the program fetch unit.
package prog_fetch_unit_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 10;
  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned MEM_BOOT_PC    = 0;
  localparam int unsigned INSTR_BYTES    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    CAPTURE  = 2'd2
  } fetch_state_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned fifo_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prog_fetch_unit_fetch_fifo.sv
// Prefetch FIFO: synchronous, power-of-two depth, flush clears contents so the head reads zero.
module prog_fetch_unit_fetch_fifo
  import prog_fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 wdata,
  output logic [WIDTH-1:0]                 rdata,
  output logic [fifo_cnt_width(DEPTH)-1:0] count,
  output logic                             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = fifo_cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/prog_fetch_unit.sv
// Instruction fetch initiator: req/gnt program memory master feeding a prefetch FIFO to decode.
module prog_fetch_unit
  import prog_fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = MEM_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BOOT_PC    = ADDR_WIDTH'(MEM_BOOT_PC),
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i
);

  localparam int unsigned CW = fifo_cnt_width(FIFO_DEPTH);
  localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  discard_q, discard_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_after_pop;
  logic [CW-1:0]         count_after_push;
  logic [EW-1:0]         head;

  assign redir_pc        = redirect_pc_i & ~ADDR_WIDTH'(INSTR_BYTES - 1);
  assign next_pc         = addr_q + ADDR_WIDTH'(INSTR_BYTES);
  // Redirect flushes the FIFO, so it also suppresses the pop of the stale head.
  assign pop             = ~empty & instr_ready_i & ~redirect_i;
  assign count_after_pop = count - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= BOOT_PC;
      addr_q    <= BOOT_PC;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      req_q     <= req_d;
    end
  end

  // Next-state, next fetch PC and FIFO push decision.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    addr_d           = addr_q;
    discard_d        = discard_q;
    push             = 1'b0;
    count_after_push = count_after_pop;

    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          addr_d  = redir_pc;
          state_d = WAIT_GNT;
        end else if (count_after_pop < CW'(FIFO_DEPTH)) begin
          addr_d  = pc_q;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        // The request cannot be withdrawn; a redirect only marks the word for dropping.
        if (redirect_i) begin
          pc_d      = redir_pc;
          discard_d = 1'b1;
        end
        if (mem_gnt_i) state_d = CAPTURE;
      end
      CAPTURE: begin
        discard_d = 1'b0;
        if (redirect_i) begin
          pc_d    = redir_pc;
          addr_d  = redir_pc;
          state_d = WAIT_GNT;
        end else begin
          if (!discard_q) begin
            push             = 1'b1;
            pc_d             = next_pc;
            count_after_push = count_after_pop + CW'(1);
          end
          if (count_after_push < CW'(FIFO_DEPTH)) begin
            addr_d  = pc_d;
            state_d = WAIT_GNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == WAIT_GNT);
  end

  prog_fetch_unit_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata ({mem_data_i, addr_q}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  assign mem_addr_o    = addr_q;
  assign mem_req_o     = req_q;
  assign instr_valid_o = ~empty;
  assign instr_o       = head[EW-1:ADDR_WIDTH];
  assign instr_pc_o    = head[ADDR_WIDTH-1:0];

endmodule
